// File: rtl/maxbw_pkg.sv
// Shared types for the maxbw pin-link transmitter.
package maxbw_pkg;

    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StCsum
    } state_e;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } maxbw_word_t;

    // Byte lane idx of a word, lane 0 is the least significant byte.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/maxbw_fifo.sv
// Synchronous word FIFO with first-word-fall-through head.
module maxbw_fifo
    import maxbw_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  maxbw_word_t wdata,
    input  logic        pop,
    output maxbw_word_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    maxbw_word_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // A full FIFO refuses a push even when a pop happens in the same cycle.
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];

    // Occupancy update; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Storage array, no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/maxbw_link_tx.sv
// Transmit end of the maxbw pin link: words in, paced byte beats plus checksum out.
module maxbw_link_tx
    import maxbw_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    input  logic             pin_ready,
    output logic [7:0]       pin_data,
    output logic [7:0]       pin_oe,
    output logic             pin_strobe,
    output logic             pin_frame,
    output logic [CNT_W-1:0] pkt_count
);

    maxbw_word_t fifo_head;
    maxbw_word_t fifo_wdata;
    logic        fifo_full, fifo_empty, fifo_pop;

    logic [1:0]       sync_q;
    logic             rdy_s;
    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       csum_q, csum_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       oe_q, oe_d;
    logic             strobe_q, strobe_d;
    logic             frame_q, frame_d;
    logic [CNT_W-1:0] pkt_q, pkt_d;
    logic [7:0]       cur_byte;

    assign fifo_wdata = '{last: in_last, data: in_data};
    assign in_ready   = !fifo_full;
    assign rdy_s      = sync_q[1];

    maxbw_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Two-flop synchronizer for the asynchronous peer ready pin.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b00;
        else     sync_q <= {sync_q[0], pin_ready};
    end

    // Next-state and beat generation for IDLE -> DATA -> CSUM.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        csum_d   = csum_q;
        data_d   = data_q;
        oe_d     = oe_q;
        strobe_d = strobe_q;
        frame_d  = frame_q;
        pkt_d    = pkt_q;
        fifo_pop = 1'b0;
        cur_byte = word_byte(fifo_head.data, idx_q);

        unique case (state_q)
            StIdle: begin
                oe_d    = {8{en}};
                frame_d = 1'b0;
                idx_d   = 2'd0;
                csum_d  = 8'd0;
                if (en && !fifo_empty) state_d = StData;
            end
            StData: begin
                // An empty FIFO here is an underrun: frame stays up, no beat.
                if (rdy_s && !fifo_empty) begin
                    data_d   = cur_byte;
                    strobe_d = !strobe_q;
                    frame_d  = 1'b1;
                    csum_d   = csum_q + cur_byte;
                    idx_d    = idx_q + 2'd1;
                    if (idx_q == 2'(BYTES_PER_WORD - 1)) begin
                        fifo_pop = 1'b1;
                        if (fifo_head.last) state_d = StCsum;
                    end
                end
            end
            StCsum: begin
                // Frame stays high over the checksum beat and drops once back in IDLE.
                if (rdy_s) begin
                    data_d   = 8'd0 - csum_q;
                    strobe_d = !strobe_q;
                    pkt_d    = pkt_q + CNT_W'(1);
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered pin outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= 2'd0;
            csum_q   <= 8'd0;
            data_q   <= 8'd0;
            oe_q     <= 8'd0;
            strobe_q <= 1'b0;
            frame_q  <= 1'b0;
            pkt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            csum_q   <= csum_d;
            data_q   <= data_d;
            oe_q     <= oe_d;
            strobe_q <= strobe_d;
            frame_q  <= frame_d;
            pkt_q    <= pkt_d;
        end
    end

    assign pin_data   = data_q;
    assign pin_oe     = oe_q;
    assign pin_strobe = strobe_q;
    assign pin_frame  = frame_q;
    assign pkt_count  = pkt_q;

endmodule

// File: tb/tb_maxbw_link_tx.sv
// Scoreboard bench for maxbw_link_tx: a byte-stream model fed on accepted pushes,
// checked by an independent strobe-watching monitor.
module tb_maxbw_link_tx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             pin_ready;
    logic [7:0]       pin_data;
    logic [7:0]       pin_oe;
    logic             pin_strobe;
    logic             pin_frame;
    logic [CNT_W-1:0] pkt_count;

    maxbw_link_tx #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .pin_ready  (pin_ready),
        .pin_data   (pin_data),
        .pin_oe     (pin_oe),
        .pin_strobe (pin_strobe),
        .pin_frame  (pin_frame),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         is_csum;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] model_sum;
    int         model_pkts;
    int         mon_pkts;
    int         beat_count;
    int         checks;
    int         errors;
    bit         rand_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference model: a packet is its words' bytes LSB first, then the negated byte sum.
    task automatic model_word(input logic [31:0] d, input logic l);
        exp_t e;
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = d[8*i +: 8];
            e.b = b;
            e.is_csum = 1'b0;
            expq.push_back(e);
            model_sum = model_sum + b;
        end
        if (l) begin
            e.b = 8'd0 - model_sum;
            e.is_csum = 1'b1;
            expq.push_back(e);
            model_sum = 8'd0;
            model_pkts++;
        end
    endtask

    // Monitor: every strobe change is one byte beat.
    initial begin
        logic prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else if (pin_strobe !== prev) begin
                prev = pin_strobe;
                beat_count++;
                check("frame_on_beat", {31'd0, pin_frame}, 32'd1);
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h want no beat", pin_data);
                end else begin
                    e = expq.pop_front();
                    if (e.is_csum) begin
                        check("csum_byte", {24'd0, pin_data}, {24'd0, e.b});
                        mon_pkts++;
                        check("pkt_count_at_csum", {16'd0, pkt_count}, {16'd0, mon_pkts[15:0]});
                    end else begin
                        check("data_byte", {24'd0, pin_data}, {24'd0, e.b});
                    end
                end
            end
        end
    end

    // Offer one word; called just after a posedge, returns just after the accepting posedge.
    task automatic push_word(input logic [31:0] d, input logic l);
        int  n;
        bit  acc;
        n = 0;
        acc = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) model_word(d, l);
            @(posedge clk);
            #1;
            n++;
            if (!acc && n > 500) begin
                checks++;
                errors++;
                $display("FAIL push_timeout: got in_ready 0 for %0d cycles want accept", n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        cycles(4);
        check({name, "_drained"}, expq.size(), 0);
        @(negedge clk);
        check({name, "_frame_low"}, {31'd0, pin_frame}, 32'd0);
        check({name, "_pkt_count"}, {16'd0, pkt_count}, {16'd0, model_pkts[15:0]});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beat_count < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("wait_beats_reached", {31'd0, beat_count >= target}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b0, bd, b1, nw;
        checks = 0;
        errors = 0;
        model_sum = 8'd0;
        model_pkts = 0;
        mon_pkts = 0;
        beat_count = 0;
        rand_done = 1'b0;
        rst = 1'b1;
        en = 1'b0;
        in_valid = 1'b0;
        in_data = 32'd0;
        in_last = 1'b0;
        pin_ready = 1'b0;
        cycles(3);
        rst = 1'b0;

        @(negedge clk);
        check("rst_pin_data", {24'd0, pin_data}, 32'd0);
        check("rst_pin_oe", {24'd0, pin_oe}, 32'd0);
        check("rst_strobe", {31'd0, pin_strobe}, 32'd0);
        check("rst_frame", {31'd0, pin_frame}, 32'd0);
        check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Disabled link: word is buffered but nothing is driven.
        pin_ready = 1'b1;
        b0 = beat_count;
        push_word(32'hCAFEF00D, 1'b1);
        cycles(10);
        check("disabled_no_beats", beat_count, b0);
        check("disabled_oe", {24'd0, pin_oe}, 32'd0);
        en = 1'b1;
        cycles(2);
        check("enabled_oe", {24'd0, pin_oe}, 32'hFF);
        drain("disabled_then_en");

        // Single word: 11 22 33 44 56.
        b0 = beat_count;
        push_word(32'h44332211, 1'b1);
        drain("single");
        check("single_beats", beat_count - b0, 5);

        // Two-word packet crossing a word boundary.
        b0 = beat_count;
        push_word(32'hFFFFFFFF, 1'b0);
        push_word(32'h00000001, 1'b1);
        drain("two_word");
        check("two_word_beats", beat_count - b0, 9);

        // Peer drops ready mid-word.
        pin_ready = 1'b0;
        cycles(4);
        push_word($urandom, 1'b0);
        push_word($urandom, 1'b0);
        push_word($urandom, 1'b1);
        b0 = beat_count;
        pin_ready = 1'b1;
        wait_beats(b0 + 2);
        pin_ready = 1'b0;
        bd = beat_count;
        cycles(4);
        b1 = beat_count;
        check("drop_at_most_3", {31'd0, (b1 - bd) <= 3}, 32'd1);
        cycles(6);
        check("drop_no_beats", beat_count, b1);
        pin_ready = 1'b1;
        drain("drop");

        // Fill to full with the peer stalled, then overflow by two.
        pin_ready = 1'b0;
        cycles(4);
        for (int i = 0; i < DEPTH; i++) push_word(32'h1000_0000 + i, 1'b0);
        @(negedge clk);
        check("full_in_ready_low", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        fork
            begin
                push_word(32'h2000_0000, 1'b0);
                push_word(32'h3000_0001, 1'b1);
            end
            begin
                cycles(6);
                pin_ready = 1'b1;
            end
        join
        drain("full");

        // Underrun between the two words of a packet.
        push_word(32'hA5A5_5A5A, 1'b0);
        cycles(10);
        b0 = beat_count;
        cycles(10);
        @(negedge clk);
        check("underrun_frame_high", {31'd0, pin_frame}, 32'd1);
        check("underrun_no_beats", beat_count, b0);
        @(posedge clk);
        #1;
        push_word(32'h0102_0304, 1'b1);
        drain("underrun");

        // Reset in the middle of a word abandons the packet.
        b0 = beat_count;
        push_word(32'hDEAD_BEEF, 1'b1);
        wait_beats(b0 + 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        expq.delete();
        model_sum = 8'd0;
        model_pkts = 0;
        mon_pkts = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_pin_data", {24'd0, pin_data}, 32'd0);
        check("midrst_pin_oe", {24'd0, pin_oe}, 32'd0);
        check("midrst_strobe", {31'd0, pin_strobe}, 32'd0);
        check("midrst_frame", {31'd0, pin_frame}, 32'd0);
        check("midrst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        push_word(32'h8765_4321, 1'b0);
        push_word(32'h0F0E_0D0C, 1'b1);
        drain("after_rst");

        // Random packets with a randomly pacing peer.
        fork
            begin
                for (int p = 0; p < 15; p++) begin
                    nw = $urandom_range(1, 3);
                    for (int w = 0; w < nw; w++) begin
                        if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 6));
                        push_word($urandom, w == nw - 1);
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    pin_ready = ($urandom_range(0, 3) != 0);
                    cycles(1);
                end
                pin_ready = 1'b1;
            end
        join
        drain("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
